twiddle_rom_gen: RTL and testbench
==================================

// Module: twiddle_rom_gen
// PURPOSE
//  Parametrised twiddle-factor generator W_N^k = cos(2πk/N) - j·sin(2πk/N) for the FFT butterflies.
//  Stores one quarter-wave cosine table and unfolds it by quadrant symmetry.
//  Delivers cos and sin together through a 3-stage pipeline, one result per cycle.
//  Sits between the FFT stage controller (which drives addresses) and the butterfly multipliers.
// PARAMETERS
//  N_POINTS  512  transform size; power of two, >= 8
//  ADDR_W    $clog2(N_POINTS)  twiddle index width
//  DATA_W    18  signed output width; scale S = 2^(DATA_W-2), so +1.0 = 65536 at 18 bits
// PORTS
//  Clk        in   1        single clock; all logic on the rising edge
//  reset      in   1        synchronous, active-high
//  ce         in   1        pipeline clock enable; 0 = freeze all state
//  in_valid   in   1        addr/inv qualify this cycle
//  addr       in   ADDR_W   twiddle index k, 0..N_POINTS-1
//  inv        in   1        1 = inverse transform, conj twiddle (sin_out = +sin)
//  cos_out    out  DATA_W   round(cos(2πk/N)·S), signed
//  sin_out    out  DATA_W   forward: round(-sin(2πk/N)·S); inv: round(+sin·S)
//  out_valid  out  1        cos_out/sin_out valid
// BEHAVIOUR
//  - Reset: out_valid=0, cos_out=0, sin_out=0; all stage valids cleared. Mid-stream reset discards in-flight samples; out_valid=0 from the next edge.
//  - Latency: 3 enabled cycles from in_valid to out_valid. No backpressure; throughput is 1 per enabled cycle.
//  - ce=0: every register holds, including valids and outputs. Inputs in that cycle are ignored.
//  - S1: q = addr[ADDR_W-1:ADDR_W-2], r = addr[ADDR_W-3:0]; ia = r, ib = N/4 - r (ADDR_W-1 bits, so it covers 0..N/4). Register q, ia, ib, inv, valid.
//  - S2: dual read of quarter table T[i] = round(cos(2πi/N)·S), i = 0..N/4 (N/4+1 entries). A = T[ia], B = T[ib].
//  - S3: quadrant unfold, with s = +sin(2πk/N):
//    - q0: cos = A,  s = B
//    - q1: cos = -B, s = A
//    - q2: cos = -A, s = -B
//    - q3: cos = B,  s = -A
//    - Then sin_out = inv ? s : -s. All terms lie in ±S, so negation cannot overflow DATA_W.
//  - addr >= N_POINTS is impossible by width; no wrap handling needed.
//  - Table is generated at elaboration with $cos; rounding is half away from zero. T[N/4] is forced to exactly 0.
// CONFIGURATION
//  - TWIDDLE_ADDR_GEN_EN defined: adds ports start(in,1), stride(in,ADDR_W), len(in,ADDR_W+1) and done(out,1), plus an internal sequencer:
//    - IDLE: on start with len!=0, latch stride/len, set k=0, go to RUN.
//    - RUN: issue k as an internal in_valid each enabled cycle; k = (k+stride) mod N.
//    - After len issues, pulse done=1 for 1 cycle in the cycle after the last issue, then return to IDLE.
//    - start during RUN is ignored; start with len=0 pulses done only.
//    - In this mode the external in_valid/addr are ignored while RUN is active. inv is sampled per issue.
//    - Reset returns to IDLE with done=0.
//  - Macro undefined: no sequencer and no extra ports; addressing is purely external.
// STRUCTURE
//  - Shared package fft_pkg holds:
//    - tw_quadrant_t enum (Q0..Q3)
//    - function tw_scale(DATA_W)
//    - function tw_quarter_entry(i, N, DATA_W) used by the ROM initialiser and the bench model
//  - One sub-module, twiddle_quarter_rom: parametrised, dual read port, registered outputs (S2 stage).
//  - Folding, unfold and sequencer stay in twiddle_rom_gen.
// TESTING (N_POINTS=512, DATA_W=18, S=65536)
//  - addr=0, inv=0 -> 3 cycles later cos=65536, sin=0, out_valid=1 for exactly 1 cycle.
//  - addr=128/256/384 -> cos/sin = 0/-65536, -65536/0, 0/+65536; repeat addr=128 with inv=1 -> sin=+65536.
//  - addr=20 -> cos=63572, sin=-15924. Then stream 0..511 back-to-back -> 512 consecutive valid outputs, in order, bit-exact vs fft_pkg model.
//  - Streaming, ce low 5 cycles mid-run -> outputs and out_valid frozen, no sample lost or duplicated after resume.
//  - reset pulsed 1 cycle mid-stream -> out_valid=0 next edge, outputs 0; first new in_valid yields out_valid exactly 3 cycles later.
//  - TWIDDLE_ADDR_GEN_EN: start, stride=4, len=128 -> k=0,4,...,508 out in order, done 1-cycle pulse after the last issue; start while RUN has no effect.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: twiddle quadrant type, sequencer states and the
// elaboration-time quarter-wave cosine table entry generator.
package fft_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } tw_quadrant_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_t;

    localparam real TW_PI = 3.14159265358979323846;

    function automatic int tw_scale(input int data_w);
        return 1 << (data_w - 2);
    endfunction

    // round(cos(2*pi*i/n) * S), half away from zero; the quarter-wave end point is pinned to 0
    function automatic int tw_quarter_entry(input int i, input int n, input int data_w);
        real x;
        if (i == n / 4) begin
            return 0;
        end
        x = $cos(2.0 * TW_PI * real'(i) / real'(n)) * real'(tw_scale(data_w));
        if (x >= 0.0) begin
            return $rtoi($floor(x + 0.5));
        end
        return -$rtoi($floor(-x + 0.5));
    endfunction

endpackage

// File: rtl/twiddle_rom_gen_quarter_rom.sv
// Quarter-wave cosine table (N/4+1 entries) with two registered read ports.
module twiddle_quarter_rom
    import fft_pkg::*;
#(
    parameter int N_POINTS = 512,
    parameter int DATA_W   = 18,
    localparam int IDX_W   = $clog2(N_POINTS) - 1
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic [IDX_W-1:0]         ia,
    input  logic [IDX_W-1:0]         ib,
    output logic signed [DATA_W-1:0] a,
    output logic signed [DATA_W-1:0] b
);

    localparam int DEPTH = N_POINTS / 4 + 1;

    logic signed [DATA_W-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        localparam int VAL = tw_quarter_entry(g, N_POINTS, DATA_W);
        assign rom[g] = DATA_W'(VAL);
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            a <= rom[ia];
            b <= rom[ib];
        end
    end

endmodule

// File: rtl/twiddle_rom_gen.sv
// Twiddle-factor generator: fold address, quarter-table lookup, quadrant unfold (3 stages).
// Optional address sequencer enabled by defining TWIDDLE_ADDR_GEN_EN.
module twiddle_rom_gen
    import fft_pkg::*;
#(
    parameter int N_POINTS = 512,
    parameter int ADDR_W   = $clog2(N_POINTS),
    parameter int DATA_W   = 18
) (
    input  logic                     Clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     inv,
`ifdef TWIDDLE_ADDR_GEN_EN
    input  logic                     start,
    input  logic [ADDR_W-1:0]        stride,
    input  logic [ADDR_W:0]          len,
    output logic                     done,
`endif
    output logic signed [DATA_W-1:0] cos_out,
    output logic signed [DATA_W-1:0] sin_out,
    output logic                     out_valid
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int QTR   = N_POINTS / 4;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;

`ifdef TWIDDLE_ADDR_GEN_EN
    seq_state_t        state;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state    <= SEQ_IDLE;
            done     <= 1'b0;
            k        <= '0;
            stride_q <= '0;
            len_q    <= '0;
            cnt      <= '0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            stride_q <= stride;
                            len_q    <= len;
                            k        <= '0;
                            cnt      <= '0;
                            state    <= SEQ_RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SEQ_RUN: begin
                    // k wraps naturally mod N since N is a power of two
                    k   <= k + stride_q;
                    cnt <= cnt + (ADDR_W+1)'(1);
                    if (cnt == len_q - (ADDR_W+1)'(1)) begin
                        state <= SEQ_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    assign iss_valid = (state == SEQ_RUN) ? 1'b1 : in_valid;
    assign iss_addr  = (state == SEQ_RUN) ? k : addr;
`else
    assign iss_valid = in_valid;
    assign iss_addr  = addr;
`endif

    // S1: split index into quadrant and mirrored table indices
    tw_quadrant_t     q1;
    logic [IDX_W-1:0] ia1;
    logic [IDX_W-1:0] ib1;
    logic             inv1;
    logic             v1;
    logic [IDX_W-1:0] r_ext;

    assign r_ext = IDX_W'(iss_addr[ADDR_W-3:0]);

    always_ff @(posedge Clk) begin
        if (reset) begin
            q1   <= Q0;
            ia1  <= '0;
            ib1  <= '0;
            inv1 <= 1'b0;
            v1   <= 1'b0;
        end else if (ce) begin
            q1   <= tw_quadrant_t'(iss_addr[ADDR_W-1:ADDR_W-2]);
            ia1  <= r_ext;
            ib1  <= IDX_W'(QTR) - r_ext;
            inv1 <= inv;
            v1   <= iss_valid;
        end
    end

    // S2: dual table read, side-band delayed alongside
    logic signed [DATA_W-1:0] tab_a;
    logic signed [DATA_W-1:0] tab_b;
    tw_quadrant_t             q2;
    logic                     inv2;
    logic                     v2;

    twiddle_quarter_rom #(
        .N_POINTS(N_POINTS),
        .DATA_W  (DATA_W)
    ) u_rom (
        .clk(Clk),
        .ce (ce),
        .ia (ia1),
        .ib (ib1),
        .a  (tab_a),
        .b  (tab_b)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            q2   <= Q0;
            inv2 <= 1'b0;
            v2   <= 1'b0;
        end else if (ce) begin
            q2   <= q1;
            inv2 <= inv1;
            v2   <= v1;
        end
    end

    // S3: quadrant unfold; s is +sin, sign flipped for the forward transform
    logic signed [DATA_W-1:0] c_val;
    logic signed [DATA_W-1:0] s_val;

    always_comb begin
        c_val = '0;
        s_val = '0;
        case (q2)
            Q0: begin c_val = tab_a;  s_val = tab_b;  end
            Q1: begin c_val = -tab_b; s_val = tab_a;  end
            Q2: begin c_val = -tab_a; s_val = -tab_b; end
            Q3: begin c_val = tab_b;  s_val = -tab_a; end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            cos_out   <= '0;
            sin_out   <= '0;
        end else if (ce) begin
            out_valid <= v2;
            if (v2) begin
                cos_out <= c_val;
                sin_out <= inv2 ? s_val : -s_val;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_rom_gen.sv
// Self-checking bench for twiddle_rom_gen (N=512, DATA_W=18) against a direct trig model.
module tb_twiddle_rom_gen;

    localparam int N  = 512;
    localparam int S  = 65536;
    localparam real PI = 3.14159265358979323846;

    logic               Clk = 1'b0;
    logic               reset = 1'b1;
    logic               ce = 1'b1;
    logic               in_valid = 1'b0;
    logic [8:0]         addr = '0;
    logic               inv = 1'b0;
    logic signed [17:0] cos_out;
    logic signed [17:0] sin_out;
    logic               out_valid;
`ifdef TWIDDLE_ADDR_GEN_EN
    logic               start = 1'b0;
    logic [8:0]         stride = '0;
    logic [9:0]         len = '0;
    logic               done;
`endif

    twiddle_rom_gen #(
        .N_POINTS(512),
        .DATA_W  (18)
    ) dut (
        .Clk      (Clk),
        .reset    (reset),
        .ce       (ce),
        .in_valid (in_valid),
        .addr     (addr),
        .inv      (inv),
`ifdef TWIDDLE_ADDR_GEN_EN
        .start    (start),
        .stride   (stride),
        .len      (len),
        .done     (done),
`endif
        .cos_out  (cos_out),
        .sin_out  (sin_out),
        .out_valid(out_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int due;
        int c;
        int s;
    } exp_t;

    exp_t eq[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   ecyc   = 0;
    int   last_c = 0;
    int   last_s = 0;
    bit   prev_v = 1'b0;
`ifdef TWIDDLE_ADDR_GEN_EN
    bit   seq_run = 1'b0;
    int   seq_k, seq_left, seq_stride;
    bit   prev_done = 1'b0;
`endif

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        return -$rtoi($floor(-x + 0.5));
    endfunction

    function automatic int ref_cos(input int k);
        return rnd($cos(2.0 * PI * real'(k) / real'(N)) * real'(S));
    endfunction

    function automatic int ref_sin(input int k, input bit iv);
        real s;
        s = $sin(2.0 * PI * real'(k) / real'(N)) * real'(S);
        return iv ? rnd(s) : rnd(-s);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input int expv);
        n_vec++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // One clock cycle: drive inputs, advance, then check against the model.
    // ovr=1 replaces the trig model by explicit constants for the issued sample.
    task automatic cyc(input bit v, input int a, input bit iv, input bit c, input bit r,
                       input bit st = 1'b0, input int ln = 0, input int sd = 0,
                       input bit ovr = 1'b0, input int oc = 0, input int os = 0);
        bit eff_v;
        int eff_a;
        bit ev;
`ifdef TWIDDLE_ADDR_GEN_EN
        bit exp_done;
        bit was_run;
        start  = st;
        len    = 10'(ln);
        stride = 9'(sd);
`endif
        in_valid = v;
        addr     = 9'(a);
        inv      = iv;
        ce       = c;
        reset    = r;
        @(posedge Clk);
        #1;
        if (r) begin
            eq.delete();
            last_c = 0;
            last_s = 0;
            prev_v = 1'b0;
            chk("rst_valid", {31'b0, out_valid}, 0);
            chk("rst_cos", cos_out, 0);
            chk("rst_sin", sin_out, 0);
`ifdef TWIDDLE_ADDR_GEN_EN
            seq_run   = 1'b0;
            prev_done = 1'b0;
            chk("rst_done", {31'b0, done}, 0);
`endif
        end else if (!c) begin
            chk("hold_valid", {31'b0, out_valid}, int'(prev_v));
            chk("hold_cos", cos_out, last_c);
            chk("hold_sin", sin_out, last_s);
`ifdef TWIDDLE_ADDR_GEN_EN
            chk("hold_done", {31'b0, done}, int'(prev_done));
`endif
        end else begin
            ecyc++;
            eff_v = v;
            eff_a = a;
`ifdef TWIDDLE_ADDR_GEN_EN
            exp_done = 1'b0;
            was_run  = seq_run;
            if (seq_run) begin
                eff_v = 1'b1;
                eff_a = seq_k;
                seq_k = (seq_k + seq_stride) % N;
                seq_left--;
                if (seq_left == 0) begin
                    seq_run  = 1'b0;
                    exp_done = 1'b1;
                end
            end
            if (st && !was_run) begin
                if (ln != 0) begin
                    seq_run    = 1'b1;
                    seq_k      = 0;
                    seq_left   = ln;
                    seq_stride = sd;
                end else begin
                    exp_done = 1'b1;
                end
            end
            chk("done", {31'b0, done}, int'(exp_done));
            prev_done = exp_done;
`endif
            if (eff_v) begin
                if (ovr) eq.push_back('{ecyc + 2, oc, os});
                else     eq.push_back('{ecyc + 2, ref_cos(eff_a), ref_sin(eff_a, iv)});
            end
            ev = (eq.size() > 0) && (eq[0].due == ecyc);
            chk("out_valid", {31'b0, out_valid}, int'(ev));
            if (ev) begin
                chk("cos", cos_out, eq[0].c);
                chk("sin", sin_out, eq[0].s);
                last_c = eq[0].c;
                last_s = eq[0].s;
                void'(eq.pop_front());
            end
            prev_v = ev;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Directed spot values
        cyc(1'b1, 0,   1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 65536, 0);
        idle(4);
        cyc(1'b1, 128, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0, -65536);
        cyc(1'b1, 256, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, -65536, 0);
        cyc(1'b1, 384, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0, 65536);
        cyc(1'b1, 128, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0, 65536);
        cyc(1'b1, 20,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 63572, -15924);
        idle(4);

        // Full sweep, back-to-back
        for (int k = 0; k < N; k++) cyc(1'b1, k, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Streaming with a 5-cycle ce stall
        for (int i = 0; i < 40; i++)
            cyc(1'b1, int'($urandom_range(N - 1)), 1'($urandom), (i < 15 || i > 19), 1'b0);
        idle(4);

        // Mid-stream reset, then a single fresh sample
        for (int i = 0; i < 10; i++) cyc(1'b1, int'($urandom_range(N - 1)), 1'($urandom), 1'b1, 1'b0);
        cyc(1'b1, 7, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, int'($urandom_range(N - 1)), 1'($urandom), 1'b1, 1'b0);
        idle(4);

        // Random mix of valid, ce, inv and occasional reset
        for (int i = 0; i < 500; i++)
            cyc(($urandom % 4) != 0, int'($urandom_range(N - 1)), 1'($urandom),
                ($urandom % 5) != 0, ($urandom % 100) == 0);
        idle(4);

`ifdef TWIDDLE_ADDR_GEN_EN
        // Sequencer: stride 4, 128 issues; a second start mid-run must be ignored
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 128, 4);
        for (int i = 0; i < 132; i++)
            cyc(1'($urandom), int'($urandom_range(N - 1)), 1'($urandom), 1'b1, 1'b0,
                (i == 50), 3, 1);
        idle(4);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 2);
        idle(2);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 7, 77);
        for (int i = 0; i < 12; i++)
            cyc(1'b0, 0, 1'($urandom), ($urandom % 3) != 0, 1'b0);
        idle(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
